// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and encodings for the two-source AXI line-fill read arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] BURST_WRAP = 2'b10;
  localparam logic [1:0] RRESP_OKAY = 2'b00;

  localparam logic SRC_IF = 1'b0;
  localparam logic SRC_DC = 1'b1;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Cache-miss request/fill signals plus the AXI read channel, bundled for the arbiter.
interface mem_read_arbiter_if #(
  parameter int unsigned ID_W = 4,
  parameter int unsigned b    = 3
);
  logic            if_req;
  logic [63:0]     if_addr;
  logic            dc_req;
  logic [63:0]     dc_addr;
  logic            fill_valid;
  logic            fill_src;
  logic [b-1:0]    fill_beat;
  logic [63:0]     fill_data;
  logic            if_done;
  logic            dc_done;
  logic            fill_err;
  logic [ID_W-1:0] m_arid;
  logic [63:0]     m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [ID_W-1:0] m_rid;
  logic [63:0]     m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;

  modport master (
    input  if_req, if_addr, dc_req, dc_addr,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output fill_valid, fill_src, fill_beat, fill_data, if_done, dc_done, fill_err,
    output m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );

  modport slave (
    output if_req, if_addr, dc_req, dc_addr,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  fill_valid, fill_src, fill_beat, fill_data, if_done, dc_done, fill_err,
    input  m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_arvalid, m_rready
  );
endinterface

// File: rtl/mem_read_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter; the pointer only moves when both contend.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant_valid,
  output logic       grant_src
);

  logic ptr;

  always_comb begin
    grant_valid = |req;
    if (&req) grant_src = ptr;
    else      grant_src = req[1] ? SRC_DC : SRC_IF;
  end

  always_ff @(posedge clk) begin
    if (reset) ptr <= SRC_IF;
    else if (accept && (&req)) ptr <= ~grant_src;
  end

endmodule

// File: rtl/mem_read_arbiter.sv
// Shares one AXI read channel between I-cache and D-cache line fills.
// Define ARB_CRITICAL_WORD_FIRST_EN for WRAP bursts that return the missed word first.
module mem_read_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned B     = 8,
  parameter int unsigned b     = 3,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned IF_ID = 0,
  parameter int unsigned DC_ID = 1
) (
  input logic clk,
  input logic reset,
  mem_read_arbiter_if.master bus
);

  localparam logic [b-1:0] LAST_BEAT = b'(B - 1);

  state_t          state;
  logic            src;
  logic [b-1:0]    idx;
  logic [b-1:0]    cnt;
  logic [63:0]     araddr;
  logic [ID_W-1:0] arid;
  logic            arvalid, rready, if_done, dc_done, fill_err;

  logic            grant_valid, grant_src, accept, beat_fire, last_beat;
  logic [63:0]     grant_addr, line_addr;
  logic [b-1:0]    start_idx;
  logic            unused_bits;

  assign accept = (state == IDLE) && grant_valid;

  rr_arbiter2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({bus.dc_req, bus.if_req}),
    .accept      (accept),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  assign grant_addr = (grant_src == SRC_DC) ? bus.dc_addr : bus.if_addr;

`ifdef ARB_CRITICAL_WORD_FIRST_EN
  assign line_addr     = {grant_addr[63:3], 3'b000};
  assign start_idx     = grant_addr[b+2:3];
  assign bus.m_arburst = BURST_WRAP;
`else
  assign line_addr     = {grant_addr[63:b+3], {(b+3){1'b0}}};
  assign start_idx     = '0;
  assign bus.m_arburst = BURST_INCR;
`endif

  // Only one burst is ever outstanding, so RID carries no information.
  assign unused_bits = ^{bus.m_rid, grant_addr[b+2:0]};

  assign beat_fire = (state == DATA) && bus.m_rvalid && rready;
  assign last_beat = (cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      src      <= SRC_IF;
      idx      <= '0;
      cnt      <= '0;
      araddr   <= '0;
      arid     <= '0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      if_done  <= 1'b0;
      dc_done  <= 1'b0;
      fill_err <= 1'b0;
    end else begin
      if_done <= 1'b0;
      dc_done <= 1'b0;
      case (state)
        IDLE: if (grant_valid) begin
          src     <= grant_src;
          araddr  <= line_addr;
          arid    <= (grant_src == SRC_DC) ? ID_W'(DC_ID) : ID_W'(IF_ID);
          arvalid <= 1'b1;
          idx     <= start_idx;
          cnt     <= '0;
          state   <= ADDR;
        end
        ADDR: if (bus.m_arready) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
          state   <= DATA;
        end
        DATA: if (beat_fire) begin
          // idx is the word index (wraps in WRAP mode); cnt alone decides completion.
          idx <= idx + 1'b1;
          cnt <= cnt + 1'b1;
          if ((bus.m_rresp != RRESP_OKAY) || (bus.m_rlast != last_beat)) fill_err <= 1'b1;
          if (last_beat) begin
            rready  <= 1'b0;
            if_done <= (src == SRC_IF);
            dc_done <= (src == SRC_DC);
            state   <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.m_arid     = arid;
  assign bus.m_araddr   = araddr;
  assign bus.m_arlen    = 8'(B - 1);
  assign bus.m_arsize   = 3'd3;
  assign bus.m_arvalid  = arvalid;
  assign bus.m_rready   = rready;
  assign bus.fill_valid = beat_fire;
  assign bus.fill_src   = src;
  assign bus.fill_beat  = beat_fire ? idx : '0;
  assign bus.fill_data  = beat_fire ? bus.m_rdata : '0;
  assign bus.if_done    = if_done;
  assign bus.dc_done    = dc_done;
  assign bus.fill_err   = fill_err;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Self-checking bench for mem_read_arbiter with a line-level reference model.
module tb_mem_read_arbiter;
  localparam int B = 8;
`ifdef ARB_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_read_arbiter_if #(.ID_W(4), .b(3)) bus ();

  mem_read_arbiter #(.B(8), .b(3), .ID_W(4), .IF_ID(0), .DC_ID(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  bit ptr_model = 1'b0;
  bit err_model = 1'b0;

  function automatic logic [63:0] exp_araddr(input logic [63:0] a);
    if (CWF) return a - (a % 8);
    return a - (a % (B * 8));
  endfunction

  function automatic int first_idx(input logic [63:0] a);
    if (CWF) return int'((a / 8) % B);
    return 0;
  endfunction

  task automatic arb_model(input bit i, input bit d, output bit w);
    if (i && d) begin
      w = ptr_model;
      ptr_model = ~ptr_model;
    end else w = d;
  endtask

  task automatic request(input bit i, input bit d, input logic [63:0] ia, input logic [63:0] da);
    @(negedge clk);
    bus.if_req = i; bus.if_addr = ia;
    bus.dc_req = d; bus.dc_addr = da;
  endtask

  task automatic serve_burst(input bit src, input logic [63:0] addr, input int ar_delay,
                             input int gap_mode, input int rresp_beat, input int rlast_beat,
                             input int reset_beat, output int waits);
    logic [63:0] exp_addr;
    logic [3:0]  exp_id;
    logic [1:0]  exp_burst;
    logic [63:0] d;
    int k, cyc, idx;
    bit first, v;
    exp_addr  = exp_araddr(addr);
    exp_id    = src ? 4'd1 : 4'd0;
    exp_burst = CWF ? 2'b10 : 2'b01;
    if (rresp_beat >= 0 && rresp_beat < B) err_model = 1'b1;
    if (rlast_beat != B - 1) err_model = 1'b1;
    waits = 0;
    while (waits < 20) begin
      @(negedge clk); waits++; #1;
      tests++;
      if (bus.fill_valid !== 1'b0) begin fails++; $display("FAIL early_fill got %b exp 0", bus.fill_valid); end
      if (bus.m_arvalid === 1'b1) break;
    end
    tests++;
    if (bus.m_arvalid !== 1'b1) begin
      fails++; $display("FAIL arvalid_timeout got %b exp 1", bus.m_arvalid);
      return;
    end
    tests++; if (bus.m_araddr !== exp_addr) begin fails++; $display("FAIL araddr got %h exp %h", bus.m_araddr, exp_addr); end
    tests++; if (bus.m_arid !== exp_id) begin fails++; $display("FAIL arid got %0d exp %0d", bus.m_arid, exp_id); end
    tests++; if (bus.m_arlen !== 8'd7) begin fails++; $display("FAIL arlen got %0d exp 7", bus.m_arlen); end
    tests++; if (bus.m_arsize !== 3'd3) begin fails++; $display("FAIL arsize got %0d exp 3", bus.m_arsize); end
    tests++; if (bus.m_arburst !== exp_burst) begin fails++; $display("FAIL arburst got %b exp %b", bus.m_arburst, exp_burst); end
    for (int s = 0; s < ar_delay; s++) begin
      @(negedge clk); #1;
      tests++;
      if (bus.m_arvalid !== 1'b1 || bus.m_araddr !== exp_addr || bus.m_arid !== exp_id || bus.fill_valid !== 1'b0) begin
        fails++;
        $display("FAIL ar_hold got vld=%b addr=%h id=%0d fv=%b exp vld=1 addr=%h id=%0d fv=0",
                 bus.m_arvalid, bus.m_araddr, bus.m_arid, bus.fill_valid, exp_addr, exp_id);
      end
    end
    bus.m_arready = 1'b1;
    @(negedge clk);
    bus.m_arready = 1'b0; #1;
    tests++; if (bus.m_arvalid !== 1'b0) begin fails++; $display("FAIL arvalid_drop got %b exp 0", bus.m_arvalid); end
    k = 0; cyc = 0; first = 1'b1;
    while (k < B && cyc < 64) begin
      if (!first) @(negedge clk);
      first = 1'b0; cyc++;
      v = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? (cyc % 2 == 1) : ($urandom_range(0, 2) != 0);
      if (k == reset_beat) v = 1'b1;
      d = {$urandom, $urandom};
      bus.m_rvalid = v;
      bus.m_rdata  = d;
      bus.m_rresp  = (v && k == rresp_beat) ? 2'd2 : 2'd0;
      bus.m_rlast  = v && (k == rlast_beat);
      if (v && k == reset_beat) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        bus.if_req = 1'b0; bus.dc_req = 1'b0;
        ptr_model = 1'b0; err_model = 1'b0; #1;
        tests++; if (bus.m_rready !== 1'b0) begin fails++; $display("FAIL rst_rready got %b exp 0", bus.m_rready); end
        tests++; if (bus.m_arvalid !== 1'b0) begin fails++; $display("FAIL rst_arvalid got %b exp 0", bus.m_arvalid); end
        tests++; if ({bus.if_done, bus.dc_done} !== 2'b00) begin fails++; $display("FAIL rst_done got %b exp 00", {bus.if_done, bus.dc_done}); end
        tests++; if (bus.fill_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", bus.fill_err); end
        return;
      end
      #1;
      tests++; if (bus.m_rready !== 1'b1) begin fails++; $display("FAIL rready k=%0d got %b exp 1", k, bus.m_rready); end
      tests++; if (bus.fill_valid !== v) begin fails++; $display("FAIL fill_valid k=%0d got %b exp %b", k, bus.fill_valid, v); end
      if (v) begin
        idx = (first_idx(addr) + k) % B;
        tests++; if (bus.fill_beat !== 3'(idx)) begin fails++; $display("FAIL fill_beat k=%0d got %0d exp %0d", k, bus.fill_beat, idx); end
        tests++; if (bus.fill_src !== src) begin fails++; $display("FAIL fill_src got %b exp %b", bus.fill_src, src); end
        tests++; if (bus.fill_data !== d) begin fails++; $display("FAIL fill_data got %h exp %h", bus.fill_data, d); end
        k++;
      end
    end
    tests++;
    if (k < B) begin fails++; $display("FAIL beat_timeout got %0d exp %0d", k, B); end
    @(negedge clk);
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rresp = 2'd0; #1;
    tests++;
    if (bus.if_done !== !src || bus.dc_done !== src) begin
      fails++; $display("FAIL done_pulse got if=%b dc=%b exp if=%b dc=%b", bus.if_done, bus.dc_done, !src, src);
    end
    tests++; if (bus.m_rready !== 1'b0) begin fails++; $display("FAIL done_rready got %b exp 0", bus.m_rready); end
    if (src) bus.dc_req = 1'b0; else bus.if_req = 1'b0;
    @(negedge clk); #1;
    tests++; if ({bus.if_done, bus.dc_done} !== 2'b00) begin fails++; $display("FAIL done_width got %b exp 00", {bus.if_done, bus.dc_done}); end
    tests++; if (bus.fill_err !== err_model) begin fails++; $display("FAIL fill_err got %b exp %b", bus.fill_err, err_model); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 0; bus.dc_req = 0; bus.if_addr = '0; bus.dc_addr = '0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rlast = 0; bus.m_rresp = 0; bus.m_rdata = '0; bus.m_rid = '0;
    repeat (3) @(negedge clk);
    #1;
    tests++;
    if (bus.m_arvalid !== 0 || bus.m_rready !== 0 || bus.if_done !== 0 || bus.dc_done !== 0 ||
        bus.fill_err !== 0 || bus.fill_valid !== 0 || bus.fill_beat !== 0 || bus.fill_data !== 0 || bus.m_araddr !== 0) begin
      fails++;
      $display("FAIL reset_state got arv=%b rr=%b done=%b%b err=%b fv=%b beat=%0d data=%h addr=%h exp all 0",
               bus.m_arvalid, bus.m_rready, bus.if_done, bus.dc_done, bus.fill_err, bus.fill_valid,
               bus.fill_beat, bus.fill_data, bus.m_araddr);
    end
    reset = 1'b0;
    ptr_model = 1'b0; err_model = 1'b0;
  endtask

  task automatic test_single();
    int w;
    request(1, 0, 64'h1234, 64'h0);
    serve_burst(1'b0, 64'h1234, 0, 0, -1, B - 1, -1, w);
    tests++; if (w !== 1) begin fails++; $display("FAIL grant_latency got %0d exp 1", w); end
  endtask

  task automatic test_simultaneous();
    bit w1, w2;
    int w;
    logic [63:0] ia, da;
    for (int p = 0; p < 2; p++) begin
      ia = 64'h8000 + 64'(p * 64'h100);
      da = 64'h9040 + 64'(p * 64'h100);
      request(1, 1, ia, da);
      arb_model(1, 1, w1);
      serve_burst(w1, w1 ? da : ia, 0, 0, -1, B - 1, -1, w);
      arb_model(w1, !w1, w2);
      serve_burst(w2, w2 ? da : ia, 0, 0, -1, B - 1, -1, w);
    end
  endtask

  task automatic test_ar_stall();
    int w;
    request(0, 1, 64'h0, 64'hABCD_0078);
    serve_burst(1'b1, 64'hABCD_0078, 5, 0, -1, B - 1, -1, w);
  endtask

  task automatic test_rvalid_gaps();
    int w;
    request(1, 0, 64'h4_0010, 64'h0);
    serve_burst(1'b0, 64'h4_0010, 1, 1, -1, B - 1, -1, w);
  endtask

  task automatic test_errors();
    int w;
    request(0, 1, 64'h0, 64'h5000);
    serve_burst(1'b1, 64'h5000, 0, 0, 3, B - 1, -1, w);
    request(1, 0, 64'h6008, 64'h0);
    serve_burst(1'b0, 64'h6008, 0, 0, -1, 5, -1, w);
    request(0, 1, 64'h0, 64'h7010);
    serve_burst(1'b1, 64'h7010, 0, 0, -1, B - 1, -1, w);
  endtask

  task automatic test_reset_mid_burst();
    int w;
    request(1, 0, 64'h2000, 64'h0);
    serve_burst(1'b0, 64'h2000, 0, 0, -1, B - 1, 4, w);
    request(0, 1, 64'h0, 64'h3318);
    serve_burst(1'b1, 64'h3318, 0, 0, -1, B - 1, -1, w);
  endtask

  task automatic test_cwf();
    int w;
    request(1, 0, 64'h1228, 64'h0);
    serve_burst(1'b0, 64'h1228, 0, 0, -1, B - 1, -1, w);
  endtask

  task automatic test_random();
    int pat, w;
    bit wa, wb;
    logic [63:0] ia, da;
    for (int n = 0; n < 10; n++) begin
      pat = $urandom_range(1, 3);
      ia = {$urandom, $urandom};
      da = {$urandom, $urandom};
      request(pat[0], pat[1], ia, da);
      arb_model(pat[0], pat[1], wa);
      serve_burst(wa, wa ? da : ia, $urandom_range(0, 3), 2, -1, B - 1, -1, w);
      if (pat == 3) begin
        arb_model(wa, !wa, wb);
        serve_burst(wb, wb ? da : ia, $urandom_range(0, 3), 2, -1, B - 1, -1, w);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_ar_stall();
    test_rvalid_gaps();
    test_random();
    test_errors();
    test_reset_mid_burst();
    if (CWF) test_cwf();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
